// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES sequencer: FSM states, register
// offsets, STATUS bit positions and 128-bit word access helpers.
package aes_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_RUN     = 2'd2,
        ST_CAPTURE = 2'd3
    } seq_state_e;

    localparam logic [5:0] OFS_CTRL   = 6'h00;
    localparam logic [5:0] OFS_STATUS = 6'h04;
    localparam logic [5:0] OFS_CYCLES = 6'h08;
    localparam logic [5:0] OFS_KEY0   = 6'h10;
    localparam logic [5:0] OFS_DIN0   = 6'h20;
    localparam logic [5:0] OFS_DOUT0  = 6'h30;

    // addr[5:4] selects a 16-byte region, addr[3:2] the word inside it
    localparam logic [1:0] RGN_MISC = 2'b00;
    localparam logic [1:0] RGN_KEY  = 2'b01;
    localparam logic [1:0] RGN_DIN  = 2'b10;
    localparam logic [1:0] RGN_DOUT = 2'b11;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLR   = 1;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;
    localparam int STAT_WR_ERR  = 3;

    // Word 0 is the most significant 32 bits of the block.
    function automatic logic [31:0] word_get(input logic [127:0] vec, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = vec[127:96];
            2'd1:    w = vec[95:64];
            2'd2:    w = vec[63:32];
            default: w = vec[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [127:0] word_put(input logic [127:0] vec, input logic [1:0] idx,
                                              input logic [31:0] w);
        logic [127:0] v;
        v = vec;
        case (idx)
            2'd0:    v[127:96] = w;
            2'd1:    v[95:64]  = w;
            2'd2:    v[63:32]  = w;
            default: v[31:0]   = w;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/aes_sequencer_if.sv
// Register access bus of the AES sequencer: write port, read strobe and
// registered read response.
interface aes_sequencer_if;
    logic        reg_wr_en;
    logic [5:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        reg_rd_en;
    logic [5:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic        reg_rd_valid;

    modport master (
        output reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr,
        input  reg_rd_data, reg_rd_valid
    );

    modport slave (
        input  reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr,
        output reg_rd_data, reg_rd_valid
    );
endinterface

// File: rtl/aes_seq_regs.sv
// Register file and address decoder: KEY/DIN/DOUT storage, sticky STATUS
// bits, CTRL command decode and the one-cycle read port.
module aes_seq_regs
    import aes_seq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    aes_sequencer_if.slave bus,
    input  logic           busy,
    input  logic           set_done,
    input  logic           set_timeout,
    input  logic           capture,
    input  logic [127:0]   cap_data,
    input  logic [31:0]    cycles,
    output logic [127:0]   key,
    output logic [127:0]   din,
    output logic           start_req
);

    logic [127:0] key_r;
    logic [127:0] din_r;
    logic [127:0] dout_r;
    logic         done_r;
    logic         timeout_r;
    logic         wr_err_r;

    logic [3:0]   wr_idx_s;
    logic [3:0]   rd_idx_s;
    logic         ctrl_wr_s;
    logic         start_cmd_s;
    logic         clr_cmd_s;
    logic         key_wr_s;
    logic         din_wr_s;
    logic         wr_err_s;
    logic [31:0]  status_s;
    logic [31:0]  rd_mux_s;
    logic         unused_addr_s;

    assign wr_idx_s    = bus.reg_wr_addr[5:2];
    assign rd_idx_s    = bus.reg_rd_addr[5:2];
    assign ctrl_wr_s   = bus.reg_wr_en && (wr_idx_s == OFS_CTRL[5:2]);
    assign start_cmd_s = ctrl_wr_s && bus.reg_wr_data[CTRL_START];
    assign clr_cmd_s   = ctrl_wr_s && bus.reg_wr_data[CTRL_CLR];
    assign key_wr_s    = bus.reg_wr_en && (wr_idx_s[3:2] == RGN_KEY);
    assign din_wr_s    = bus.reg_wr_en && (wr_idx_s[3:2] == RGN_DIN);
    assign wr_err_s    = busy && (key_wr_s || din_wr_s || start_cmd_s);
    assign start_req   = start_cmd_s && !busy;
    assign key         = key_r;
    assign din         = din_r;
    assign unused_addr_s = ^{bus.reg_wr_addr[1:0], bus.reg_rd_addr[1:0]};

    // STATUS word assembly
    always_comb begin
        status_s               = 32'd0;
        status_s[STAT_BUSY]    = busy;
        status_s[STAT_DONE]    = done_r;
        status_s[STAT_TIMEOUT] = timeout_r;
        status_s[STAT_WR_ERR]  = wr_err_r;
    end

    // Read data selection; CTRL and unmapped offsets read as zero
    always_comb begin
        rd_mux_s = 32'd0;
        case (rd_idx_s[3:2])
            RGN_MISC: begin
                if (rd_idx_s[1:0] == OFS_STATUS[3:2]) begin
                    rd_mux_s = status_s;
                end else if (rd_idx_s[1:0] == OFS_CYCLES[3:2]) begin
                    rd_mux_s = cycles;
                end else begin
                    rd_mux_s = 32'd0;
                end
            end
            RGN_KEY:  rd_mux_s = word_get(key_r, rd_idx_s[1:0]);
            RGN_DIN:  rd_mux_s = word_get(din_r, rd_idx_s[1:0]);
            RGN_DOUT: rd_mux_s = word_get(dout_r, rd_idx_s[1:0]);
            default:  rd_mux_s = 32'd0;
        endcase
    end

    // Register state, sticky status (clear applied before new sets) and read port
    always_ff @(posedge clk) begin
        if (rst) begin
            key_r            <= 128'd0;
            din_r            <= 128'd0;
            dout_r           <= 128'd0;
            done_r           <= 1'b0;
            timeout_r        <= 1'b0;
            wr_err_r         <= 1'b0;
            bus.reg_rd_data  <= 32'd0;
            bus.reg_rd_valid <= 1'b0;
        end else begin
            if (key_wr_s && !busy) begin
                key_r <= word_put(key_r, wr_idx_s[1:0], bus.reg_wr_data);
            end
            if (din_wr_s && !busy) begin
                din_r <= word_put(din_r, wr_idx_s[1:0], bus.reg_wr_data);
            end
            if (capture) begin
                dout_r <= cap_data;
            end
            done_r    <= (done_r && !clr_cmd_s) || set_done;
            timeout_r <= (timeout_r && !clr_cmd_s) || set_timeout;
            wr_err_r  <= (wr_err_r && !clr_cmd_s) || wr_err_s;
            bus.reg_rd_valid <= bus.reg_rd_en;
            bus.reg_rd_data  <= bus.reg_rd_en ? rd_mux_s : 32'd0;
        end
    end

endmodule

// File: rtl/aes_sequencer.sv
// AES sequencer top: launches the external AES core, counts RUN cycles,
// enforces the completion timeout and drives the scope trigger.
module aes_sequencer
    import aes_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TRIG_DELAY     = 0
) (
    input  logic           ACLK,
    input  logic           ARESET,
    aes_sequencer_if.slave bus,
    output logic [127:0]   aes_key,
    output logic [127:0]   aes_din,
    output logic           aes_start,
    input  logic           aes_done,
    input  logic [127:0]   aes_dout,
    output logic           trigger,
    output logic           busy
);

    localparam logic [31:0] TIMEOUT_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] TRIG_DELAY_W  = 32'(TRIG_DELAY);
    localparam logic        TRIG_AT_START = (TRIG_DELAY == 0);

    seq_state_e   state_r;
    logic [31:0]  cycles_r;
    logic [31:0]  trig_cnt_r;
    logic [127:0] dout_hold_r;

    logic         start_req_s;
    logic         timeout_hit_s;
    logic         trig_hit_s;
    logic [31:0]  trig_next_s;
    logic         set_done_s;
    logic         set_timeout_s;

    assign timeout_hit_s = (cycles_r == TIMEOUT_LAST);
    assign trig_next_s   = (trig_cnt_r == 32'hFFFF_FFFF) ? trig_cnt_r : trig_cnt_r + 32'd1;
    assign trig_hit_s    = (trig_next_s == TRIG_DELAY_W);
    assign set_done_s    = (state_r == ST_CAPTURE);
    // aes_done wins over a coincident timeout
    assign set_timeout_s = (state_r == ST_RUN) && !aes_done && timeout_hit_s;

    aes_seq_regs u_regs (
        .clk         (ACLK),
        .rst         (ARESET),
        .bus         (bus),
        .busy        (busy),
        .set_done    (set_done_s),
        .set_timeout (set_timeout_s),
        .capture     (set_done_s),
        .cap_data    (dout_hold_r),
        .cycles      (cycles_r),
        .key         (aes_key),
        .din         (aes_din),
        .start_req   (start_req_s)
    );

    // Sequencer FSM with RUN counter, trigger delay counter and registered outputs
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r     <= ST_IDLE;
            cycles_r    <= 32'd0;
            trig_cnt_r  <= 32'd0;
            dout_hold_r <= 128'd0;
            aes_start   <= 1'b0;
            trigger     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_req_s) begin
                        state_r    <= ST_START;
                        aes_start  <= 1'b1;
                        busy       <= 1'b1;
                        trigger    <= TRIG_AT_START;
                        trig_cnt_r <= 32'd0;
                    end else begin
                        aes_start  <= 1'b0;
                        busy       <= 1'b0;
                        trigger    <= 1'b0;
                    end
                end
                ST_START: begin
                    state_r    <= ST_RUN;
                    aes_start  <= 1'b0;
                    cycles_r   <= 32'd0;
                    trig_cnt_r <= trig_next_s;
                    trigger    <= trigger || trig_hit_s;
                end
                ST_RUN: begin
                    cycles_r   <= (cycles_r == 32'hFFFF_FFFF) ? cycles_r : cycles_r + 32'd1;
                    trig_cnt_r <= trig_next_s;
                    if (aes_done) begin
                        state_r     <= ST_CAPTURE;
                        dout_hold_r <= aes_dout;
                        trigger     <= 1'b0;
                    end else if (timeout_hit_s) begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                        trigger <= 1'b0;
                    end else begin
                        trigger <= trigger || trig_hit_s;
                    end
                end
                ST_CAPTURE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    trigger <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    aes_start <= 1'b0;
                    busy      <= 1'b0;
                    trigger   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_sequencer.md
AES_SEQUENCER -- requirements
Module: aes_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles waited for aes_done before abort.
REQ-002 SHALL have parameter TRIG_DELAY, default 0, cycles between aes_start and trigger assertion.
REQ-003 SHALL have port ACLK  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port ARESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports reg_wr_en/reg_wr_addr/reg_wr_data  in  1/6/32  register write strobe, byte address, data.
REQ-006 SHALL have ports reg_rd_en/reg_rd_addr  in  1/6  register read strobe, byte address.
REQ-007 SHALL have ports reg_rd_data/reg_rd_valid  out  32/1  read data and valid.
REQ-008 SHALL have ports aes_key/aes_din  out  128/128  key and plaintext to the AES core.
REQ-009 SHALL have port aes_start  out  1  one-cycle start pulse to the core.
REQ-010 SHALL have ports aes_done/aes_dout  in  1/128  core completion pulse and ciphertext.
REQ-011 SHALL have port trigger  out  1  SCA scope trigger, high while encryption runs.
REQ-012 SHALL have port busy  out  1  high outside IDLE.

Function
REQ-013 Register map SHALL be decoded on addr[5:2]: 0x00 CTRL(W), 0x04 STATUS(R), 0x08 CYCLES(R), 0x10-0x1C KEY0-3(RW), 0x20-0x2C DIN0-3(RW), 0x30-0x3C DOUT0-3(R).
REQ-014 Word 0 of KEY/DIN/DOUT SHALL map to bits [127:96]; word 3 SHALL map to bits [31:0].
REQ-015 CTRL writes: bit0 START and bit1 CLR_STATUS SHALL be self-clearing commands; they SHALL never read back.
REQ-016 STATUS SHALL be bit0 busy, bit1 done (sticky), bit2 timeout (sticky), bit3 wr_err (sticky); the other bits SHALL read 0.
REQ-017 Reads SHALL have 1-cycle latency: reg_rd_valid=1 and reg_rd_data valid in the cycle after reg_rd_en; unmapped addresses SHALL read 0.
REQ-018 FSM SHALL have states IDLE, START, RUN, CAPTURE.
REQ-019 IDLE->START SHALL occur on a CTRL.START write; in START, aes_start=1 for exactly one cycle; then START->RUN.
REQ-020 In RUN, CYCLES SHALL increment by one each cycle, counting from 0 on RUN entry.
REQ-021 RUN->CAPTURE SHALL occur on aes_done=1; CAPTURE SHALL latch aes_dout into DOUT, set done, then go to IDLE.
REQ-022 If CYCLES reaches TIMEOUT_CYCLES-1 without aes_done, RUN->IDLE SHALL occur, setting timeout and leaving DOUT unchanged.
REQ-023 trigger SHALL rise TRIG_DELAY cycles after aes_start and SHALL fall in the cycle the FSM leaves RUN.
REQ-024 aes_done in the same cycle the timeout limit is reached SHALL take precedence: CAPTURE, no timeout.
REQ-025 aes_done outside RUN SHALL be ignored.
REQ-026 KEY/DIN writes while busy=1 SHALL be dropped and SHALL set wr_err; a START while busy SHALL be dropped and SHALL set wr_err.
REQ-027 CLR_STATUS and START written in the same word SHALL clear done/timeout/wr_err, then start.
REQ-028 A simultaneous read and write to the same register SHALL return the pre-write value.
REQ-029 CYCLES SHALL saturate at 2^32-1.
REQ-030 aes_key and aes_din SHALL be driven continuously from KEY and DIN.

Reset
REQ-031 While ARESET=1, FSM=IDLE, and KEY, DIN, DOUT, CYCLES, STATUS, reg_rd_data, reg_rd_valid, aes_start, trigger and busy SHALL be 0.
REQ-032 ARESET asserted mid-RUN SHALL abort without setting any status bit; a later aes_done SHALL be ignored.

Structure
REQ-033 A package aes_seq_pkg SHALL hold the FSM state enum, register offset constants and STATUS bit indices.
REQ-034 The register file/decoder SHALL be one sub-module, aes_seq_regs; the FSM, counter and trigger SHALL live in aes_sequencer.

Verification
REQ-035 Bench SHALL use a core stub with dout=din XOR key and aes_done 10 cycles after aes_start.
REQ-036 Normal run: KEY=000102..0f, DIN=00112233..ff, START -> one aes_start pulse; DOUT0-3=00102030,40506070,8090a0b0,c0d0e0f0; STATUS=0x2; CYCLES=9 or 10, whichever matches the counting rule.
REQ-037 Timeout: stub never asserts done, TIMEOUT_CYCLES=16 -> STATUS=0x4 after 16 RUN cycles; trigger falls; DOUT=0.
REQ-038 Busy protection: write KEY0=0xdeadbeef during RUN -> KEY0 unchanged; STATUS bit3=1; result as REQ-036.
REQ-039 Reset mid-RUN: ARESET for 1 cycle at RUN cycle 5 -> all outputs 0 next cycle; a late aes_done leaves STATUS=0.
REQ-040 CTRL=0x3 after a run -> STATUS cleared, then a new run; aes_done coincident with the timeout limit -> done=1, timeout=0.
